cache_axi_arbiter: RTL
======================

Name: cache_axi_arbiter

Overview:
- Shares one AXI master port between the ICache line-refill requester and the DCache line-refill/writeback requester.
- Accepts one 128-bit line request at a time and arbitrates when both requesters are valid.
- Sequences the AXI AR/R or AW/W/B channels as a 4-beat INCR burst.
- Returns the refill line, or a write-done pulse, to the granted cache.

Parameters:
- LINE_WORDS, 4: 32-bit beats per cache line; must be a power of 2, ≤16.
- ID_I, 4'd0: AXI ID used for ICache reads.
- ID_D, 4'd1: AXI ID used for DCache reads and writes.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- i_req_valid/i_req_ready  in/out  1/1  ICache request handshake
- i_req_addr  in  32  ICache line address
- i_resp_valid/i_resp_ready  out/in  1/1  ICache response handshake
- i_resp_line  out  32*LINE_WORDS  ICache refill line
- d_req_valid/d_req_ready  in/out  1/1  DCache request handshake
- d_req_addr  in  32  DCache line address
- d_req_we  in  1  1 = writeback, 0 = refill
- d_req_wline  in  32*LINE_WORDS  writeback line
- d_resp_valid/d_resp_ready  out/in  1/1  DCache refill response handshake
- d_resp_line  out  32*LINE_WORDS  DCache refill line
- d_wdone  out  1  one-cycle pulse when a writeback completes
- d_wresp  out  2  BRESP captured for that writeback
- resp_err  out  1  sticky flag: any RRESP/BRESP ≠ 0; cleared by reset only
- arid, araddr, arlen, arsize, arburst, arprot, arvalid / arready  out / in  4,32,4,3,2,3,1 / 1  AXI read address channel
- rdata, rresp, rlast, rvalid / rready  in / out  32,2,1,1 / 1  AXI read data channel
- awid, awaddr, awlen, awsize, awburst, awprot, awvalid / awready  out / in  4,32,4,3,2,3,1 / 1  AXI write address channel
- wid, wdata, wstrb, wlast, wvalid / wready  out / in  4,32,4,1,1 / 1  AXI write data channel
- bresp, bvalid / bready  in / out  2,1 / 1  AXI write response channel

Behaviour:
- States: IDLE, AR, R, RSP, AW, W, B, WD.
- Reset value of every output is 0, except fixed fields:
  - arlen/awlen = LINE_WORDS-1
  - arsize/awsize = 3'b010
  - arburst/awburst = 2'b01
  - arprot/awprot = 0
  - wstrb = 4'hF
- IDLE:
  - *_req_ready = 1 for the granted requester only (combinational grant).
  - On acceptance, register:
    - address with bits[$clog2(LINE_WORDS)+1:0] forced to 0
    - requester ID
    - we
    - write line
  - Go to AW if DCache with we = 1; otherwise go to AR.
- Arbitration, both valid:
  - Round-robin: the last-granted requester loses.
  - last_grant resets to ICache, so DCache wins the first tie.
- AR:
  - arvalid = 1 and arid = captured ID.
  - arvalid is held stable until arready is seen.
  - On arready, go to R and clear the beat counter.
- R:
  - rready = 1.
  - Each rvalid writes rdata into line word[cnt]; word 0 = bits[31:0]. Then cnt increments.
  - The transfer ends on the beat where cnt = LINE_WORDS-1, then goes to RSP.
  - rresp ≠ 0 sets resp_err.
  - If rlast disagrees with cnt (rlast=1 with cnt≠LINE_WORDS-1, or rlast=0 on the final beat), resp_err is set; the beat count still governs termination.
- RSP:
  - The granted *_resp_valid is held with its line until *_resp_ready, then go to IDLE.
  - The non-granted resp_valid stays 0.
- AW:
  - awvalid = 1 and awid = ID_D.
  - On awready, go to W with cnt = 0.
- W:
  - wvalid = 1, wid = ID_D, wdata = wline word[cnt], wlast = (cnt == LINE_WORDS-1).
  - cnt advances on wready.
  - After the last beat is accepted, go to B.
- B:
  - bready = 1.
  - On bvalid, capture bresp into d_wresp; bresp ≠ 0 sets resp_err.
  - Then go to WD.
- WD:
  - d_wdone = 1 for exactly one cycle, then go to IDLE.
  - A writeback produces no d_resp_valid.
- Only one transaction is outstanding at a time; no new request is accepted outside IDLE.
- Latency: best case, accept → arvalid on the next cycle; 6 cycles from accept to resp_valid with LINE_WORDS = 4.
- Async reset mid-burst: all valids drop immediately and the FSM returns to IDLE. This AXI protocol break is acceptable under system reset.
- The requester's valid may drop after acceptance without effect.

Optional Feature:
- ARB_DPRIO_EN
  - Defined: fixed priority, DCache always wins a tie.
  - Undefined: round-robin as specified above.

Decomposition:
- Shared package holds:
  - state enum type
  - AXI constants: BURST_INCR = 2'b01, SIZE_4B = 3'b010, RESP_OKAY = 2'b00
  - ID_I/ID_D defaults
- One natural sub-module: cache_arb_rr, a 2-input round-robin/priority grant with the last_grant register.

Test Plan:
- ICache read 0x1000_0014, AR accepted immediately, rdata 0xA0..0xA3 → araddr = 0x1000_0010, arid = 0, i_resp_line = {A3,A2,A1,A0}, resp_valid 6 cycles after accept.
- Simultaneous I/D read after reset → DCache granted first (arid = 1). Repeat simultaneous → ICache granted. With ARB_DPRIO_EN → DCache both times.
- DCache writeback 0x2000_0000, line {4,3,2,1}, wready toggling 1/0 → wdata sequence 1,2,3,4, wlast only on beat 4, d_wdone single pulse after bvalid, d_wresp = 0.
- arready held low 5 cycles → arvalid/araddr stable throughout; no grant to the other requester.
- rresp = 2'b10 on beat 2 → line still delivered, resp_err = 1 and sticky. bresp = 2'b11 → d_wresp = 3.
- rst asserted mid-R burst → all AXI valids/readies and resp_valids go 0 asynchronously; after release the next request is accepted normally.

Source files
------------

// File: rtl/cache_axi_arbiter_pkg.sv
// Shared types and AXI constants for the ICache/DCache AXI arbiter.
package cache_axi_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE, AR, R, RSP, AW, W, B, WD
    } state_e;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    localparam logic [3:0] ID_I_DEFAULT = 4'd0;
    localparam logic [3:0] ID_D_DEFAULT = 4'd1;

endpackage

// File: rtl/cache_axi_arbiter_if.sv
// Cache request/response handshakes and the shared AXI master port.
interface cache_axi_arbiter_if #(
    parameter int unsigned LINE_WORDS = 4
);
    localparam int unsigned LW = 32 * LINE_WORDS;

    logic          i_req_valid,  i_req_ready;
    logic [31:0]   i_req_addr;
    logic          i_resp_valid, i_resp_ready;
    logic [LW-1:0] i_resp_line;

    logic          d_req_valid,  d_req_ready;
    logic [31:0]   d_req_addr;
    logic          d_req_we;
    logic [LW-1:0] d_req_wline;
    logic          d_resp_valid, d_resp_ready;
    logic [LW-1:0] d_resp_line;
    logic          d_wdone;
    logic [1:0]    d_wresp;
    logic          resp_err;

    logic [3:0]    arid;
    logic [31:0]   araddr;
    logic [3:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic [2:0]    arprot;
    logic          arvalid, arready;

    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rlast, rvalid, rready;

    logic [3:0]    awid;
    logic [31:0]   awaddr;
    logic [3:0]    awlen;
    logic [2:0]    awsize;
    logic [1:0]    awburst;
    logic [2:0]    awprot;
    logic          awvalid, awready;

    logic [3:0]    wid;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          wlast, wvalid, wready;

    logic [1:0]    bresp;
    logic          bvalid, bready;

    modport master (
        input  i_req_valid, i_req_addr, i_resp_ready,
        output i_req_ready, i_resp_valid, i_resp_line,
        input  d_req_valid, d_req_addr, d_req_we, d_req_wline, d_resp_ready,
        output d_req_ready, d_resp_valid, d_resp_line, d_wdone, d_wresp, resp_err,
        output arid, araddr, arlen, arsize, arburst, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        output i_req_valid, i_req_addr, i_resp_ready,
        input  i_req_ready, i_resp_valid, i_resp_line,
        output d_req_valid, d_req_addr, d_req_we, d_req_wline, d_resp_ready,
        input  d_req_ready, d_resp_valid, d_resp_line, d_wdone, d_wresp, resp_err,
        input  arid, araddr, arlen, arsize, arburst, arprot, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/cache_arb_rr.sv
// Two-input grant: round-robin on ties, or fixed DCache priority when ARB_DPRIO_EN is defined.
module cache_arb_rr (
    input  logic clk,
    input  logic rst,
    input  logic req_i,
    input  logic req_d,
    input  logic en,
    output logic gnt_i_c,
    output logic gnt_d_c
);

`ifdef ARB_DPRIO_EN
    always_comb begin
        gnt_i_c = req_i && !req_d;
        gnt_d_c = req_d;
    end
`else
    logic last_d;

    // On a tie the requester that won last time yields; reset favours DCache first.
    always_comb begin
        gnt_i_c = 1'b0;
        gnt_d_c = 1'b0;
        if (req_i && req_d) begin
            gnt_i_c = last_d;
            gnt_d_c = !last_d;
        end else begin
            gnt_i_c = req_i;
            gnt_d_c = req_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_d <= 1'b0;
        end else if (en && (gnt_i_c || gnt_d_c)) begin
            last_d <= gnt_d_c;
        end
    end
`endif

endmodule

// File: rtl/cache_axi_arbiter.sv
// Shares one AXI master between ICache refills and DCache refills/writebacks, one line burst at a time.
// Optional: ARB_DPRIO_EN selects fixed DCache priority instead of round-robin.
module cache_axi_arbiter
    import cache_axi_arbiter_pkg::*;
#(
    parameter int unsigned LINE_WORDS = 4,
    parameter logic [3:0]  ID_I       = ID_I_DEFAULT,
    parameter logic [3:0]  ID_D       = ID_D_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    cache_axi_arbiter_if.master bus
);

    localparam int unsigned CW  = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int unsigned LW  = 32 * LINE_WORDS;
    localparam int unsigned OFF = $clog2(LINE_WORDS) + 2;
    localparam logic [CW-1:0] LAST      = CW'(LINE_WORDS - 1);
    localparam logic [31:0]   ADDR_MASK = ~((32'd1 << OFF) - 32'd1);

    state_e        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          is_d, is_d_n;
    logic [LW-1:0] line_q;
    logic          gnt_i_c, gnt_d_c;
    logic          idle_c, accept_c;

    assign idle_c   = (state == IDLE);
    assign accept_c = idle_c && (bus.i_req_valid || bus.d_req_valid);

    cache_arb_rr u_arb (
        .clk     (clk),
        .rst     (rst),
        .req_i   (bus.i_req_valid),
        .req_d   (bus.d_req_valid),
        .en      (idle_c),
        .gnt_i_c (gnt_i_c),
        .gnt_d_c (gnt_d_c)
    );

    assign bus.i_req_ready = idle_c && gnt_i_c;
    assign bus.d_req_ready = idle_c && gnt_d_c;
    assign bus.i_resp_line = line_q;
    assign bus.d_resp_line = line_q;

    assign bus.arlen   = 4'(LINE_WORDS - 1);
    assign bus.arsize  = SIZE_4B;
    assign bus.arburst = BURST_INCR;
    assign bus.arprot  = 3'b000;
    assign bus.awlen   = 4'(LINE_WORDS - 1);
    assign bus.awsize  = SIZE_4B;
    assign bus.awburst = BURST_INCR;
    assign bus.awprot  = 3'b000;
    assign bus.wstrb   = 4'hF;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            is_d  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            is_d  <= is_d_n;
        end
    end

    // Beat count alone ends a burst; rlast is only checked for consistency.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        is_d_n  = accept_c ? gnt_d_c : is_d;
        unique case (state)
            IDLE: if (accept_c) state_n = (gnt_d_c && bus.d_req_we) ? AW : AR;
            AR:   if (bus.arready) begin state_n = R; cnt_n = '0; end
            R:    if (bus.rvalid) begin
                      if (cnt == LAST) state_n = RSP;
                      else             cnt_n   = cnt + CW'(1);
                  end
            RSP:  if (is_d ? bus.d_resp_ready : bus.i_resp_ready) state_n = IDLE;
            AW:   if (bus.awready) begin state_n = W; cnt_n = '0; end
            W:    if (bus.wready) begin
                      if (cnt == LAST) state_n = B;
                      else             cnt_n   = cnt + CW'(1);
                  end
            B:    if (bus.bvalid) state_n = WD;
            WD:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Channel controls are registered from the next state so they appear with the state itself.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_q           <= '0;
            bus.araddr       <= '0;
            bus.awaddr       <= '0;
            bus.arid         <= '0;
            bus.arvalid      <= 1'b0;
            bus.rready       <= 1'b0;
            bus.awid         <= '0;
            bus.awvalid      <= 1'b0;
            bus.wid          <= '0;
            bus.wdata        <= '0;
            bus.wlast        <= 1'b0;
            bus.wvalid       <= 1'b0;
            bus.bready       <= 1'b0;
            bus.i_resp_valid <= 1'b0;
            bus.d_resp_valid <= 1'b0;
            bus.d_wdone      <= 1'b0;
            bus.d_wresp      <= '0;
            bus.resp_err     <= 1'b0;
        end else begin
            if (accept_c) begin
                bus.araddr <= (gnt_d_c ? bus.d_req_addr : bus.i_req_addr) & ADDR_MASK;
                bus.awaddr <= (gnt_d_c ? bus.d_req_addr : bus.i_req_addr) & ADDR_MASK;
                if (gnt_d_c && bus.d_req_we) line_q <= bus.d_req_wline;
            end
            if (state == R && bus.rvalid) begin
                line_q[{cnt, 5'd0} +: 32] <= bus.rdata;
                if (bus.rresp != RESP_OKAY || bus.rlast != (cnt == LAST)) bus.resp_err <= 1'b1;
            end
            if (state == B && bus.bvalid) begin
                bus.d_wresp <= bus.bresp;
                if (bus.bresp != RESP_OKAY) bus.resp_err <= 1'b1;
            end

            bus.arvalid      <= (state_n == AR);
            bus.arid         <= (state_n == AR) ? (is_d_n ? ID_D : ID_I) : 4'd0;
            bus.rready       <= (state_n == R);
            bus.awvalid      <= (state_n == AW);
            bus.awid         <= (state_n == AW) ? ID_D : 4'd0;
            bus.wvalid       <= (state_n == W);
            bus.wid          <= (state_n == W) ? ID_D : 4'd0;
            bus.wdata        <= (state_n == W) ? line_q[{cnt_n, 5'd0} +: 32] : 32'd0;
            bus.wlast        <= (state_n == W) && (cnt_n == LAST);
            bus.bready       <= (state_n == B);
            bus.i_resp_valid <= (state_n == RSP) && !is_d_n;
            bus.d_resp_valid <= (state_n == RSP) && is_d_n;
            bus.d_wdone      <= (state_n == WD);
        end
    end

endmodule
